product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_W, default 72: accumulator and result width in bits; legal range 64 or greater.
REQ-002 Parameter CNT_W, default 8: beat-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_p and in_last are valid this cycle.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_p  input  64  unsigned 64-bit product from the 32x32 multiplier stage.
REQ-008 in_last  input  1  marks the final beat of the current group.
REQ-009 out_valid  output  1  group result is presented.
REQ-010 out_ready  input  1  consumer accepts the presented result.
REQ-011 out_sum  output  ACC_W  unsigned sum of the group, modulo 2^ACC_W.
REQ-012 out_count  output  CNT_W  beats in the group; saturating.
REQ-013 out_ovf  output  1  sticky flag: a carry out of ACC_W occurred during the group.

Function
REQ-014 The block SHALL have two states: ACCUM (accepting beats) and HOLD (result presented).
REQ-015 in_ready SHALL equal (state==ACCUM), decoded directly from the state register; out_valid SHALL equal (state==HOLD).
REQ-016 A beat SHALL be accepted only when in_valid && in_ready.
REQ-017 On accept, the accumulator SHALL become acc + zero-extend(in_p), truncated to ACC_W.
REQ-018 On accept, ovf SHALL be set when that addition carries out of bit ACC_W-1; ovf SHALL never clear within a group.
REQ-019 On accept, count SHALL increment, saturating at 2^CNT_W-1 and never wrapping.
REQ-020 An accept with in_last=1 SHALL move the block to HOLD; out_sum, out_count and out_ovf SHALL include that beat and become visible the next cycle (latency 1).
REQ-021 In HOLD, out_sum, out_count and out_ovf SHALL remain stable until the cycle in which out_ready=1.
REQ-022 In HOLD, in_ready SHALL be 0, and in_valid, in_p and in_last SHALL be ignored.
REQ-023 HOLD with out_ready=1 SHALL return the block to ACCUM and clear acc, count and ovf, so that in_ready=1 the next cycle.
REQ-024 In a HOLD cycle where out_ready=1 and in_valid=1 occur together, no beat SHALL be accepted; the beat is accepted in a following cycle.
REQ-025 out_sum, out_count and out_ovf SHALL be driven directly from the acc, count and ovf registers; no separate result copy is kept.
REQ-026 Peak throughput SHALL be one beat per cycle in ACCUM; each group costs N+1 cycles when out_ready is held at 1.
REQ-027 A group of length 1 (in_last on the first beat) SHALL be legal.
REQ-028 out_ready outside HOLD SHALL have no effect.

Reset
REQ-029 While rst=1 at a clock edge, the next state SHALL be ACCUM, and acc, count and ovf SHALL be 0.
REQ-030 After reset: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
REQ-031 rst SHALL take priority over every other input in the same cycle.
REQ-032 Reset mid-group SHALL discard the partial sum.
REQ-033 Reset in HOLD SHALL drop the presented result without a handshake.

Verification
REQ-034 Single-beat group: reset, then in_p=6, in_last=1, in_valid=1 for 1 cycle -> next cycle out_valid=1, out_sum=6, out_count=1, out_ovf=0; out_ready=1 -> in_ready=1 the following cycle.
REQ-035 Max-product sum: 3 beats of in_p=0xFFFFFFFE00000001, the third with in_last=1 -> out_sum=0x2FFFFFFFA00000003, out_count=3, out_ovf=0.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 with in_p=7 -> out_sum and out_count stable, in_ready=0, no beat accepted; the next group still starts from acc=0.
REQ-037 Overflow and saturation, with ACC_W=64: 2 beats of 0xFFFFFFFE00000001 -> out_sum=0xFFFFFFFC00000002, out_ovf=1.
REQ-038 Overflow and saturation, with CNT_W=8: 300 beats of in_p=1 -> out_sum=300, out_count=255.
REQ-039 Reset mid-group: accept 2 beats of in_p=10, pulse rst for 1 cycle, then send in_p=5 with in_last=1 -> out_sum=5, out_count=1.
REQ-040 Reset in HOLD: with out_valid=1, pulse rst -> next cycle out_valid=0, in_ready=1, out_sum=0.
REQ-041 Each scenario SHALL be checked every cycle against a reference model; the bench reports the total mismatch count at the end.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Product-beat input stream and group-result output stream of the product accumulator.
// Latency: none (wires only); the block adds one cycle from last beat to result.
// Backpressure: in_ready deasserts while a result waits; out_ready releases it.
interface product_accumulator_if #(
   parameter int ACC_W = 72,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_p;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   // Producer of beats and consumer of results.
   modport master (
      output in_valid, in_p, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   // The accumulator itself.
   modport slave (
      input  in_valid, in_p, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums groups of 64-bit products into an ACC_W accumulator with saturating beat count and sticky carry flag.
// Latency: result visible 1 cycle after the in_last beat; one beat per cycle while accumulating.
// Backpressure: in_ready=0 while the result is held; the hold lasts until out_ready=1, then state clears.
module product_accumulator #(
   parameter int ACC_W = 72,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   product_accumulator_if.slave bus
);
   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   // One extra bit on top of the accumulator captures the carry out of ACC_W.
   logic [ACC_W:0]   sum_ext;
   assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - 64){1'b0}}, bus.in_p};

   // State and accumulator registers; reset wins over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state: accumulate beats in ACCUM, hold the result until out_ready, then clear.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         ACCUM: begin
            if (bus.in_valid) begin
               acc_d = sum_ext[ACC_W-1:0];
               ovf_d = ovf_q | sum_ext[ACC_W];
               if (count_q != {CNT_W{1'b1}}) begin
                  count_d = count_q + {{(CNT_W - 1){1'b0}}, 1'b1};
               end
               if (bus.in_last) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Input side is ignored here, so a beat offered alongside out_ready waits a cycle.
            if (bus.out_ready) begin
               state_d = ACCUM;
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // Handshakes decode straight from the state register; results are the live registers.
   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_sum   = acc_q;
   assign bus.out_count = count_q;
   assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Drives identical beat streams into a 72-bit and a 64-bit accumulator and checks both against a group-level model.
// Latency: checks every cycle on the falling edge; literal checks one cycle after the relevant edge.
// Backpressure: exercises held results with in_valid asserted and out_ready low, then released.
module tb_product_accumulator;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_p;
   logic        in_last;
   logic        out_ready;

   int n_total;
   int n_pass;
   bit cmp_en;

   product_accumulator_if #(.ACC_W(72), .CNT_W(8)) b72 ();
   product_accumulator_if #(.ACC_W(64), .CNT_W(8)) b64 ();

   assign b72.in_valid  = in_valid;
   assign b72.in_p      = in_p;
   assign b72.in_last   = in_last;
   assign b72.out_ready = out_ready;
   assign b64.in_valid  = in_valid;
   assign b64.in_p      = in_p;
   assign b64.in_last   = in_last;
   assign b64.out_ready = out_ready;

   product_accumulator #(.ACC_W(72), .CNT_W(8)) dut72 (.clk(clk), .rst(rst), .bus(b72));
   product_accumulator #(.ACC_W(64), .CNT_W(8)) dut64 (.clk(clk), .rst(rst), .bus(b64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: exact unbounded group sum, beat count and whether a result is held.
   logic [127:0] m_exact;
   int           m_n;
   bit           m_hold;

   always @(posedge clk) begin
      if (rst) begin
         m_hold  = 1'b0;
         m_exact = '0;
         m_n     = 0;
      end else if (m_hold) begin
         if (out_ready) begin
            m_hold  = 1'b0;
            m_exact = '0;
            m_n     = 0;
         end
      end else if (in_valid) begin
         m_exact = m_exact + {64'd0, in_p};
         m_n     = m_n + 1;
         if (in_last) m_hold = 1'b1;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [7:0] ecnt;
         ecnt = (m_n > 255) ? 8'd255 : 8'(m_n);
         check("m72_in_ready",  {127'd0, b72.in_ready},  {127'd0, !m_hold});
         check("m72_out_valid", {127'd0, b72.out_valid}, {127'd0, m_hold});
         check("m72_out_sum",   {56'd0, b72.out_sum},    {56'd0, m_exact[71:0]});
         check("m72_out_count", {120'd0, b72.out_count}, {120'd0, ecnt});
         check("m72_out_ovf",   {127'd0, b72.out_ovf},   {127'd0, (m_exact[127:72] != 0)});
         check("m64_in_ready",  {127'd0, b64.in_ready},  {127'd0, !m_hold});
         check("m64_out_valid", {127'd0, b64.out_valid}, {127'd0, m_hold});
         check("m64_out_sum",   {64'd0, b64.out_sum},    {64'd0, m_exact[63:0]});
         check("m64_out_count", {120'd0, b64.out_count}, {120'd0, ecnt});
         check("m64_out_ovf",   {127'd0, b64.out_ovf},   {127'd0, (m_exact[127:64] != 0)});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] p, input logic last);
      in_valid = 1'b1;
      in_p     = p;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   localparam logic [63:0] MAXP = 64'hFFFF_FFFE_0000_0001;

   initial begin
      n_total   = 0;
      n_pass    = 0;
      cmp_en    = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_p      = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      step();
      cmp_en = 1'b1;
      step();
      rst = 1'b0;

      // Reset state
      check("rst_in_ready",  {127'd0, b72.in_ready},  128'd1);
      check("rst_out_valid", {127'd0, b72.out_valid}, 128'd0);
      check("rst_out_sum",   {56'd0, b72.out_sum},    128'd0);
      check("rst_out_count", {120'd0, b72.out_count}, 128'd0);
      check("rst_out_ovf",   {127'd0, b72.out_ovf},   128'd0);

      // Single-beat group
      beat(64'd6, 1'b1);
      check("single_valid", {127'd0, b72.out_valid}, 128'd1);
      check("single_sum",   {56'd0, b72.out_sum},    128'd6);
      check("single_count", {120'd0, b72.out_count}, 128'd1);
      check("single_ovf",   {127'd0, b72.out_ovf},   128'd0);
      release_result();
      check("single_rdy_after", {127'd0, b72.in_ready}, 128'd1);

      // Max-product sum with out_ready held high throughout (no effect while accumulating)
      out_ready = 1'b1;
      beat(MAXP, 1'b0);
      beat(MAXP, 1'b0);
      beat(MAXP, 1'b1);
      check("max_sum72",   {56'd0, b72.out_sum},    128'h2_FFFF_FFFA_0000_0003);
      check("max_count",   {120'd0, b72.out_count}, 128'd3);
      check("max_ovf72",   {127'd0, b72.out_ovf},   128'd0);
      check("max_sum64",   {64'd0, b64.out_sum},    128'hFFFF_FFFA_0000_0003);
      check("max_ovf64",   {127'd0, b64.out_ovf},   128'd1);
      step();
      out_ready = 1'b0;
      check("max_released", {127'd0, b72.in_ready}, 128'd1);

      // Backpressure: result held while beats are offered, then beat taken only after release
      beat(64'd3, 1'b0);
      beat(64'd4, 1'b1);
      in_valid = 1'b1;
      in_p     = 64'd7;
      in_last  = 1'b1;
      repeat (5) step();
      check("bp_sum",      {56'd0, b72.out_sum},    128'd7);
      check("bp_count",    {120'd0, b72.out_count}, 128'd2);
      check("bp_in_ready", {127'd0, b72.in_ready},  128'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_released_empty", {56'd0, b72.out_sum}, 128'd0);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("bp_next_sum",   {56'd0, b72.out_sum},    128'd7);
      check("bp_next_count", {120'd0, b72.out_count}, 128'd1);
      release_result();

      // Carry out of a 64-bit accumulator
      beat(MAXP, 1'b0);
      beat(MAXP, 1'b1);
      check("ovf_sum64", {64'd0, b64.out_sum},  128'hFFFF_FFFC_0000_0002);
      check("ovf_ovf64", {127'd0, b64.out_ovf}, 128'd1);
      check("ovf_sum72", {56'd0, b72.out_sum},  128'h1_FFFF_FFFC_0000_0002);
      check("ovf_ovf72", {127'd0, b72.out_ovf}, 128'd0);
      release_result();
      check("ovf_cleared", {127'd0, b64.out_ovf}, 128'd0);

      // Count saturation
      for (int i = 0; i < 300; i++) beat(64'd1, (i == 299));
      check("sat_sum",   {56'd0, b72.out_sum},    128'd300);
      check("sat_count", {120'd0, b72.out_count}, 128'd255);
      release_result();

      // Reset mid-group discards the partial sum
      beat(64'd10, 1'b0);
      beat(64'd10, 1'b0);
      pulse_rst();
      beat(64'd5, 1'b1);
      check("midrst_sum",   {56'd0, b72.out_sum},    128'd5);
      check("midrst_count", {120'd0, b72.out_count}, 128'd1);

      // Reset in HOLD drops the result
      check("holdrst_pre_valid", {127'd0, b72.out_valid}, 128'd1);
      pulse_rst();
      check("holdrst_valid",    {127'd0, b72.out_valid}, 128'd0);
      check("holdrst_in_ready", {127'd0, b72.in_ready},  128'd1);
      check("holdrst_sum",      {56'd0, b72.out_sum},    128'd0);

      step();
      step();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
